// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    LINE_WAIT,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_sync2
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= UART_IDLE_LVL;
      q    <= UART_IDLE_LVL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start/stop checking, valid/ready output
// with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_s;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // busy is kept as a registered copy of (state != IDLE), updated on every transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LINE_WAIT;
      busy      <= 1'b1;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        LINE_WAIT: begin
          if (rx_s == UART_IDLE_LVL) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clk_cnt <= '0;
          end
        end

        IDLE: begin
          if (rx_s != UART_IDLE_LVL) begin
            state   <= START;
            busy    <= 1'b1;
            clk_cnt <= '0;
          end
        end

        // Re-check the start bit at its midpoint to reject glitches
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (rx_s == UART_IDLE_LVL) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // Leaving mid-stop-bit lets a back-to-back start edge be caught
        STOP: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            if (rx_s == UART_IDLE_LVL) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!out_valid || out_ready) begin
                out_data  <= shift;
                out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state     <= LINE_WAIT;
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= LINE_WAIT;
          busy    <= 1'b1;
          clk_cnt <= '0;
        end
      endcase
    end
  end

endmodule
